// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the fetch front end and its testbench.
package riscv_pkg;

  localparam int XLEN = 32;

  // ADDI x0, x0, 0: the canonical RISC-V NOP.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetch triples between the imem response port and IF/ID.
// Flush empties it in one cycle; the head is presented combinationally.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_flush,
  input  logic                        i_push,
  input  fetch_entry_t                i_push_entry,
  input  logic                        i_pop,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output fetch_entry_t                o_head
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  fetch_entry_t     entries_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // A flush voids any push or pop requested in the same cycle.
  assign do_pop  = i_pop && !i_flush && (count_q != '0);
  assign do_push = i_push && !i_flush && ((count_q != FULL_CNT) || do_pop);

  // NOTE: the entry array is deliberately not reset; count_q alone says which
  // slots hold live data, so resetting storage would only cost flops.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      entries_q[wr_ptr_q] <= i_push_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_count = count_q;
  assign o_head  = entries_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited sequential requests to imem,
// in-order response buffering, and redirect handling that drops stale fetches.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stallD,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_validF,
  output logic [31:0] o_pcF,
  output logic [31:0] o_pc_nxtF,
  output logic [31:0] o_instrF
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] CREDIT_LIMIT = SUM_W'(FIFO_DEPTH);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  rsp_pc_q;
  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] outstanding_nxt;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0] fifo_count;
  logic [SUM_W-1:0] credit_used;
  logic [XLEN-1:0]  redirect_target;

  logic         req_fire;
  logic         rsp_drop;
  logic         fifo_push;
  logic         fifo_pop;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign redirect_target = word_align(i_redirect_pc);

  // Every issued request owns a FIFO slot until its entry is popped, so a
  // response can never find the buffer full.
  assign credit_used      = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign o_imem_req_valid = !i_rst && !i_redirect && (credit_used < CREDIT_LIMIT);
  assign o_imem_req_addr  = pc_q;
  assign req_fire         = o_imem_req_valid && i_imem_req_ready;

  assign rsp_drop   = i_imem_rsp_valid && (drop_cnt_q != '0);
  assign fifo_push  = i_imem_rsp_valid && !rsp_drop && !i_redirect;
  assign fifo_pop   = o_validF && !i_stallD && !i_redirect;
  assign push_entry = '{pc: rsp_pc_q, pc_nxt: rsp_pc_q + 32'd4, instr: i_imem_rsp_data};

  // NOTE: always_comb assigns a default before any condition so no path can
  // leave the signal unassigned and infer a latch.
  always_comb begin
    outstanding_nxt = outstanding_q;
    if (req_fire && !i_imem_rsp_valid) begin
      outstanding_nxt = outstanding_q + CNT_W'(1);
    end else if (!req_fire && i_imem_rsp_valid) begin
      outstanding_nxt = outstanding_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else if (i_redirect) begin
      // Everything still in flight after this edge belongs to the old path.
      pc_q          <= redirect_target;
      rsp_pc_q      <= redirect_target;
      outstanding_q <= outstanding_nxt;
      drop_cnt_q    <= outstanding_nxt;
    end else begin
      if (req_fire) begin
        pc_q <= pc_q + 32'd4;
      end
      if (fifo_push) begin
        rsp_pc_q <= rsp_pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_cnt_q <= drop_cnt_q - CNT_W'(1);
      end
      outstanding_q <= outstanding_nxt;
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (i_redirect),
    .i_push       (fifo_push),
    .i_push_entry (push_entry),
    .i_pop        (fifo_pop),
    .o_count      (fifo_count),
    .o_head       (head)
  );

  assign o_validF  = (fifo_count != '0);
  assign o_pcF     = o_validF ? head.pc     : '0;
  assign o_pc_nxtF = o_validF ? head.pc_nxt : '0;
  assign o_instrF  = o_validF ? head.instr  : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: an in-order variable-latency
// memory model, an expected fetch stream per control-flow segment, and a monitor.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_stallD;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        o_validF;
  logic [31:0] o_pcF;
  logic [31:0] o_pc_nxtF;
  logic [31:0] o_instrF;

  always #5 i_clk = ~i_clk;

  fetch_unit #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_stallD         (i_stallD),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .o_validF         (o_validF),
    .o_pcF            (o_pcF),
    .o_pc_nxtF        (o_pc_nxtF),
    .o_instrF         (o_instrF)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- expected fetch stream (scoreboard) ----------------
  fetch_entry_t exp_q[$];
  logic [31:0]  model_pc;

  task automatic restart_model(input logic [31:0] start_pc);
    exp_q.delete();
    model_pc = start_pc & ~32'h3;
  endtask

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{pc: model_pc, pc_nxt: model_pc + 32'd4, instr: mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          mem_lat_min = 1;
  int          mem_lat_max = 1;
  int          ready_pct   = 100;
  int          acc_seg     = 0;
  logic [31:0] exp_req_addr = RESET_PC;

  initial begin
    int          mem_cyc  = 0;
    int          last_due = 0;
    int          due;
    bit          s_rst;
    bit          s_acc;
    logic [31:0] s_addr;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    forever begin
      @(negedge i_clk);
      s_rst  = i_rst;
      s_acc  = o_imem_req_valid && i_imem_req_ready;
      s_addr = o_imem_req_addr;
      if (s_acc) begin
        check("req_addr", s_addr, exp_req_addr);
        exp_req_addr = exp_req_addr + 32'd4;
        acc_seg++;
      end
      if (i_redirect) check("req_gated_redirect", o_imem_req_valid, 1'b0);
      if (s_rst) begin
        exp_req_addr = RESET_PC;
        acc_seg      = 0;
      end else if (i_redirect) begin
        exp_req_addr = i_redirect_pc & ~32'h3;
        acc_seg      = 0;
      end
      @(posedge i_clk);
      #1;
      mem_cyc++;
      if (s_rst) begin
        pend.delete();
        last_due = 0;
      end else if (s_acc) begin
        due = mem_cyc - 1 + int'($urandom_range(mem_lat_max, mem_lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{addr: s_addr, due: due});
      end
      if (pend.size() > 0 && pend[0].due <= mem_cyc) begin
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = $urandom;
      end
      i_imem_req_ready = (int'($urandom_range(99, 0)) < ready_pct);
    end
  end

  // ---------------- monitor ----------------
  int pop_cnt = 0;
  int pop_seg = 0;

  initial begin
    bit           prev_rst   = 1'b1;
    bit           prev_redir = 1'b0;
    bit           hold_prev  = 1'b0;
    logic [95:0]  held       = '0;
    logic [95:0]  cur;
    fetch_entry_t e;
    forever begin
      @(negedge i_clk);
      cur = {o_pcF, o_pc_nxtF, o_instrF};
      if (prev_rst) begin
        check("reset_outputs", {o_validF, cur}, {1'b0, 32'h0, 32'h0, NOP_INSTR});
        check("reset_req_addr", o_imem_req_addr, RESET_PC);
      end
      if (i_rst) check("req_gated_reset", o_imem_req_valid, 1'b0);
      if (prev_redir && !prev_rst) check("flush_after_redirect", o_validF, 1'b0);
      if (hold_prev) check("stall_hold", {o_validF, cur}, {1'b1, held});
      if (!o_validF) begin
        check("empty_outputs", cur, {32'h0, 32'h0, NOP_INSTR});
      end else if (!i_stallD && !i_redirect && !i_rst) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("fetch_triple", cur, e);
        end
        pop_cnt++;
        pop_seg++;
      end
      hold_prev = o_validF && i_stallD && !i_redirect && !i_rst;
      held      = cur;
      if (i_redirect || i_rst) pop_seg = 0;
      prev_rst   = i_rst;
      prev_redir = i_redirect;
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
      top_up();
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    i_redirect    = 1'b1;
    i_redirect_pc = target;
    restart_model(target);
    step(1);
    i_redirect    = 1'b0;
    i_redirect_pc = $urandom;
  endtask

  // Counts sampled cycles, starting with the current one, until o_validF.
  task automatic wait_valid(input string name, input int exp_n);
    int n = 0;
    int i = 0;
    while (n == 0 && i < 20) begin
      i++;
      @(negedge i_clk);
      if (o_validF) n = i;
    end
    check(name, n, exp_n);
    step(1);
  endtask

  initial begin
    int p0;
    int i;
    i_rst         = 1'b1;
    i_stallD      = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    restart_model(RESET_PC);

    // Reset release with L=1: first entry three cycles later, then 1/cycle.
    step(3);
    i_rst = 1'b0;
    wait_valid("first_valid_latency", 3);
    p0 = pop_cnt;
    step(10);
    check("throughput_l1", pop_cnt - p0, 10);

    // Long decode stall: credit limit stops requests, outputs hold.
    i_stallD = 1'b1;
    step(8);
    check("stall_req_blocked", o_imem_req_valid, 1'b0);
    check("stall_credit_used", acc_seg - pop_seg, FIFO_DEPTH);
    i_stallD = 1'b0;
    step(6);

    // Redirect coinciding with a response and a pop.
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0200;
    restart_model(32'h0000_0200);
    @(negedge i_clk);
    check("coincident_setup", {i_imem_rsp_valid, o_validF}, 2'b11);
    step(1);
    i_redirect = 1'b0;
    @(negedge i_clk);
    check("coincident_flush", {o_validF, o_instrF}, {1'b0, NOP_INSTR});
    step(8);

    // Address wrap at the top of the address space.
    do_redirect(32'hFFFF_FFF8);
    i = 0;
    while (i < 20 && !(o_validF && o_pcF == 32'hFFFF_FFFC)) begin
      i++;
      @(negedge i_clk);
    end
    check("wrap_pc_nxt", {o_pcF, o_pc_nxtF}, {32'hFFFF_FFFC, 32'h0});
    step(8);

    // Redirect with two requests in flight at L=3.
    mem_lat_min = 3;
    mem_lat_max = 3;
    i_rst = 1'b1;
    restart_model(RESET_PC);
    step(2);
    i_rst = 1'b0;
    step(2);
    check("two_in_flight", acc_seg, 2);
    do_redirect(32'h0000_0103);
    wait_valid("redirect_latency_l3", 5);
    step(10);

    // Reset mid-stream with a full FIFO.
    mem_lat_min = 1;
    mem_lat_max = 1;
    i_stallD = 1'b1;
    step(10);
    check("full_before_reset", o_imem_req_valid, 1'b0);
    i_rst = 1'b1;
    restart_model(RESET_PC);
    step(1);
    i_rst    = 1'b0;
    i_stallD = 1'b0;
    wait_valid("restart_latency", 3);
    step(5);

    // Randomized traffic: stalls, backpressure, latency 1..4, redirects, resets.
    mem_lat_max = 4;
    ready_pct   = 70;
    for (int c = 0; c < 800; c++) begin
      i_stallD = ($urandom_range(99, 0) < 30);
      if ($urandom_range(999, 0) < 8) begin
        i_rst      = 1'b1;
        i_redirect = ($urandom_range(1, 0) == 1);
        restart_model(RESET_PC);
      end else if ($urandom_range(99, 0) < 4) begin
        i_rst         = 1'b0;
        i_redirect    = 1'b1;
        i_redirect_pc = $urandom;
        restart_model(i_redirect_pc);
      end else begin
        i_rst      = 1'b0;
        i_redirect = 1'b0;
      end
      step(1);
    end
    i_rst      = 1'b0;
    i_redirect = 1'b0;
    i_stallD   = 1'b0;
    ready_pct  = 100;
    step(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that generates the fetch-stage triple (PC, PC+4, instruction) consumed by the IF/ID pipeline register. It issues PC-sequential requests to a variable-latency instruction memory, buffers in-order responses in a small FIFO, and presents the FIFO head to IF/ID. It honours decode stalls, and on an execute-stage redirect it discards all buffered and in-flight fetches.

## Interface
- FIFO_DEPTH, 4: fetch buffer entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_stallD  in  1  decode stall; the head is not consumed this cycle.
- i_redirect  in  1  taken branch/jump from EX; restart fetch.
- i_redirect_pc  in  32  new fetch address; bits [1:0] forced to 0.
- o_imem_req_valid  out  1  request valid.
- i_imem_req_ready  in  1  memory accepts the request.
- o_imem_req_addr  out  32  word-aligned fetch address.
- i_imem_rsp_valid  in  1  response valid; responses return in request order, no backpressure.
- i_imem_rsp_data  in  32  instruction word.
- o_validF  out  1  the outputs below hold a real instruction.
- o_pcF  out  32  PC of the presented instruction.
- o_pc_nxtF  out  32  o_pcF + 4.
- o_instrF  out  32  instruction, or NOP 32'h0000_0013 when o_validF=0.

## Operation
- Request address register pc_q. A request is accepted when o_imem_req_valid && i_imem_req_ready; on accept, pc_q <= pc_q + 4 (mod 2^32) and outstanding is incremented.
- Credit rule: o_imem_req_valid = !i_rst && !i_redirect && (outstanding + fifo_count < FIFO_DEPTH). Every in-flight response is therefore guaranteed a slot. Responses that arrive when the FIFO is full are impossible by construction.
- Response handling:
  - If drop_cnt > 0, the response is discarded and drop_cnt is decremented.
  - Otherwise, {pc_rsp, pc_rsp+4, data} is pushed. pc_rsp comes from a response-PC register that is advanced by 4 on each push.
  - Every response decrements outstanding.
- Pop: when o_validF && !i_stallD, the head is removed. IF/ID captures it on the same edge.
- Empty FIFO: o_validF=0, o_pcF=0, o_pc_nxtF=0, o_instrF=NOP.
- Redirect (highest priority among non-reset events):
  - The FIFO is flushed.
  - pc_q and the response-PC register are set to {i_redirect_pc[31:2],2'b00}.
  - drop_cnt is set to the count of requests that are in flight after this edge: outstanding, minus a response arriving this cycle, plus a request accepted this cycle. A request accepted in the redirect cycle is not possible because req_valid is gated.
  - Any push or pop in that cycle is void.
- Simultaneous push and pop: fifo_count is unchanged. Pop of an empty FIFO never occurs.
- The memory is reset by the same i_rst, so no responses arrive after reset for pre-reset requests.

## Timing
- Reset values:
  - pc_q = RESET_PC; response-PC register = RESET_PC.
  - fifo_count = 0; outstanding = 0; drop_cnt = 0.
  - o_validF = 0; o_pcF = 0; o_pc_nxtF = 0; o_instrF = NOP; o_imem_req_valid = 0 during reset.
  - o_imem_req_addr = RESET_PC.
- The outputs are combinational from the FIFO head. There is no response-to-output bypass.
- Memory latency L cycles, from the accept cycle to the rsp_valid cycle:
  - Redirect asserted in cycle N → request for the new PC at N+1.
  - Response at N+1+L.
  - o_validF with the new PC at N+2+L.
- After reset, the first request is in the cycle following reset deassertion.
- Steady state with L=1 and FIFO_DEPTH ≥ 3: one instruction per cycle, provided i_stallD=0.
- i_stallD held: the head and all o_* outputs are stable. Requests continue until the credit limit is reached, then o_imem_req_valid=0.
- A redirect during a stall still flushes. In the next cycle o_validF=0.

## Structure
- The shared package riscv_pkg holds:
  - the NOP constant 32'h0000_0013;
  - typedef fetch_entry_t {pc, pc_nxt, instr};
  - XLEN=32.
- Sub-module fetch_fifo: a synchronous FIFO of fetch_entry_t with push, pop, flush, count, and head outputs, parameterised by FIFO_DEPTH. The top level holds pc_q, the response-PC register, the outstanding/drop counters, and the credit logic.

## Test plan
- Reset, L=1, no stall:
  - Required: o_validF rises 3 cycles after reset deassert with o_pcF=0, o_pc_nxtF=4.
  - Required: thereafter one entry per cycle with PCs 0,4,8,12 and instructions matching memory.
- i_stallD held 6 cycles with FIFO_DEPTH=4:
  - Required: o_* stable throughout.
  - Required: o_imem_req_valid drops once outstanding + count = 4.
  - Required: after release, PCs continue with no gap or duplicate.
- Redirect to 32'h0000_0103 while 2 requests are in flight (L=3):
  - Required: the 2 stale responses are dropped.
  - Required: the next valid output has o_pcF=32'h100, o_pc_nxtF=32'h104.
- Redirect in the same cycle as a response and a pop:
  - Required: the response is dropped, the FIFO is empty next cycle, and o_instrF=NOP.
- Fetch at pc_q=32'hFFFF_FFFC:
  - Required: o_pc_nxtF=0 and the next request address is 0.
- Assert i_rst mid-stream with a full FIFO:
  - Required: all outputs return to reset values on the next edge.
  - Required: fetch restarts at RESET_PC.
